// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/prefetch_unit_if.sv
// Fetch-side memory bus, control inputs and instruction stream of the prefetch unit.
interface prefetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_code;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  stall, redirect, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_code, inst_pc
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_code, inst_pc
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Instruction queue: DEPTH entries of {code, pc}, head visible combinationally,
// flush clears occupancy without touching storage.
module prefetch_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [2*XLEN-1:0]        push_data,
  input  logic                     pop,
  output logic [2*XLEN-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              do_push;
  logic              do_pop;

  // Guards keep occupancy in range even if a caller misbehaves.
  assign do_push = push & (count_reg != FULL_C);
  assign do_pop  = pop & (count_reg != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/prefetch_unit.sv
// Single-outstanding instruction prefetcher feeding a small queue.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the consumer when the queue is empty.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  prefetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t            state_reg;
  state_t            state_next;
  logic [XLEN-1:0]   fetch_pc_reg;
  logic [XLEN-1:0]   fetch_pc_next;
  logic [XLEN-1:0]   target_pc;
  logic              issue;
  logic              keep;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] head_data;
  logic [XLEN-1:0]   head_code;
  logic [XLEN-1:0]   head_pc;

  assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  // In IDLE nothing is outstanding, so count < DEPTH guarantees a free slot on response.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    issue         = 1'b0;
    keep          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_next = target_pc;
        end else if (!bus.stall && (fifo_count < DEPTH_C)) begin
          issue      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.redirect) begin
          fetch_pc_next = target_pc;
          state_next    = bus.imem_rvalid ? IDLE : DROP;
        end else if (bus.imem_rvalid) begin
          keep          = 1'b1;
          fetch_pc_next = fetch_pc_reg + XLEN'(PC_INC);
          state_next    = IDLE;
        end
      end
      DROP: begin
        if (bus.redirect) fetch_pc_next = target_pc;
        if (bus.imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with reset keeps the request low while reset is held.
  assign bus.imem_req  = issue & reset;
  assign bus.imem_addr = fetch_pc_reg;

  assign fifo_empty = (fifo_count == '0);
  assign head_code  = fifo_empty ? '0 : head_data[2*XLEN-1:XLEN];
  assign head_pc    = fifo_empty ? '0 : head_data[XLEN-1:0];
  assign pop        = ~fifo_empty & bus.inst_ready & ~bus.stall;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;
  logic accept;

  assign bypass         = keep & fifo_empty;
  assign bus.inst_valid = ~fifo_empty | bypass;
  assign bus.inst_code  = bypass ? bus.imem_rdata : head_code;
  assign bus.inst_pc    = bypass ? fetch_pc_reg : head_pc;
  assign accept         = bus.inst_valid & bus.inst_ready & ~bus.stall;
  assign push           = keep & ~(bypass & accept);
`else
  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_code  = head_code;
  assign bus.inst_pc    = head_pc;
  assign push           = keep;
`endif

  prefetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data ({bus.imem_rdata, fetch_pc_reg}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

endmodule
